// File: rtl/lfsr_6bit_checker.sv
// Purpose : locks onto a received x^6+x^5+1 LFSR word stream and flags words that break the sequence.
// Latency : one cycle; a word sampled on edge N is reflected on locked/err/err_count after edge N.
// Backpres: none; data_valid=0 cycles hold all state, and the block is always ready.
//
// Ports:
//   clk         - single clock, all state updates on the rising edge
//   rst_n       - asynchronous active-low reset
//   data_valid  - data_in carries one LFSR state word this cycle
//   data_in     - received 6-bit LFSR state word
//   clear_cnt   - synchronous clear of err_count (wins over a same-cycle increment)
//   locked      - registered, high while the checker is in LOCKED
//   err         - registered one-cycle pulse per mismatching word while LOCKED
//   err_count   - saturating count of mismatches seen while LOCKED
//
// Build option: define LFSR_CHK_ERR_CNT_EN to implement the err_count counter.
// Without it err_count is tied to zero and clear_cnt is ignored.
module lfsr_6bit_checker #(
    parameter int LOCK_COUNT     = 4,  // consecutive matches needed for lock (1..15)
    parameter int LOSS_THRESHOLD = 3   // consecutive locked mismatches forcing resync (1..15)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [5:0]  data_in,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_THRESHOLD);

    // Shift-left Fibonacci step for x^6 + x^5 + 1.
    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    state_t     state;
    logic [5:0] expected;
    logic [3:0] match_cnt;
    logic [3:0] err_run;

    logic word_hit;
    logic word_zero;
    logic locked_miss;

    assign word_hit    = (data_in == expected);
    assign word_zero   = (data_in == 6'd0);
    // A mismatch that is counted: valid word, LOCKED, not the expected value.
    assign locked_miss = data_valid && (state == LOCKED) && !word_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            expected  <= 6'd0;
            match_cnt <= 4'd0;
            err_run   <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            // err is a pulse: it only survives the cycle after a counted mismatch.
            err <= 1'b0;
            if (data_valid) begin
                case (state)
                    IDLE: begin
                        // The all-zero word is the LFSR lock-up state and cannot seed.
                        if (!word_zero) begin
                            expected  <= lfsr_next(data_in);
                            match_cnt <= 4'd0;
                            state     <= SYNC;
                        end
                    end

                    SYNC: begin
                        if (word_hit) begin
                            expected <= lfsr_next(data_in);
                            if (match_cnt + 4'd1 == LOCK_N) begin
                                match_cnt <= 4'd0;
                                err_run   <= 4'd0;
                                locked    <= 1'b1;
                                state     <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else if (!word_zero) begin
                            // Treat the unexpected word as a fresh seed.
                            expected  <= lfsr_next(data_in);
                            match_cnt <= 4'd0;
                        end else begin
                            match_cnt <= 4'd0;
                            state     <= IDLE;
                        end
                    end

                    LOCKED: begin
                        // Flywheel: advance from our own prediction so a single
                        // corrupted word cannot drag the reference off sequence.
                        expected <= lfsr_next(expected);
                        if (word_hit) begin
                            err_run <= 4'd0;
                        end else begin
                            err <= 1'b1;
                            if (err_run + 4'd1 == LOSS_N) begin
                                err_run <= 4'd0;
                                locked  <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                err_run <= err_run + 4'd1;
                            end
                        end
                    end

                    default: begin
                        match_cnt <= 4'd0;
                        err_run   <= 4'd0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_ERR_CNT_EN
    logic [15:0] err_count_q;

    // clear_cnt takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 16'h0000;
        end else if (clear_cnt) begin
            err_count_q <= 16'h0000;
        end else if (locked_miss && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_cnt_inputs;

    assign unused_cnt_inputs = clear_cnt ^ locked_miss;
    assign err_count         = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_6bit_checker.sv
// Purpose : self-checking bench for lfsr_6bit_checker with a sequence-position model.
// Latency : model outputs are those expected after the edge that sampled each word.
// Backpres: not applicable; stimulus drives one word (or idle) per cycle.
module tb_lfsr_6bit_checker;

    localparam int LOCK_COUNT     = 4;
    localparam int LOSS_THRESHOLD = 3;
`ifdef LFSR_CHK_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_valid;
    logic [5:0]  data_in;
    logic        clear_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    lfsr_6bit_checker #(
        .LOCK_COUNT    (LOCK_COUNT),
        .LOSS_THRESHOLD(LOSS_THRESHOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_valid(data_valid),
        .data_in   (data_in),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // The LFSR orbit is held as a table of 63 words; the model tracks a
    // position within it instead of a shift register.
    logic [5:0] seq [63];
    int         pos_of [64];

    int mode;      // 0 = idle, 1 = acquiring, 2 = locked
    int m_pos;     // position of the most recently accepted word
    int m_match;   // matches seen since the seed
    int m_run;     // consecutive misses while locked
    bit m_locked;
    bit m_err;
    int m_cnt;

    task automatic build_table();
        logic [5:0] s;
        s = 6'd1;
        for (int i = 0; i < 63; i++) begin
            seq[i]    = s;
            pos_of[s] = i;
            s = {s[4:0], s[5] ^ s[4]};
        end
    endtask

    task automatic m_reset();
        mode = 0; m_pos = 0; m_match = 0; m_run = 0;
        m_locked = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic m_step(input bit v, input logic [5:0] d, input bit clr);
        m_err = 1'b0;
        if (v) begin
            if (mode == 0) begin
                if (d != 6'd0) begin
                    m_pos = pos_of[d]; m_match = 0; mode = 1;
                end
            end else if (mode == 1) begin
                if (d == seq[(m_pos + 1) % 63]) begin
                    m_pos = (m_pos + 1) % 63;
                    m_match++;
                    if (m_match == LOCK_COUNT) begin
                        mode = 2; m_run = 0;
                    end
                end else if (d != 6'd0) begin
                    m_pos = pos_of[d]; m_match = 0;
                end else begin
                    mode = 0;
                end
            end else begin
                m_pos = (m_pos + 1) % 63;
                if (d != seq[m_pos]) begin
                    m_err = 1'b1;
                    m_run++;
                    if (CNT_EN && m_cnt < 65535) m_cnt++;
                    if (m_run == LOSS_THRESHOLD) begin
                        mode = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (CNT_EN && clr) m_cnt = 0;
        m_locked = (mode == 2);
    endtask

    // One compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("locked", {31'd0, locked}, {31'd0, m_locked});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("err_count", {16'd0, err_count}, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    // Drives one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input bit v, input logic [5:0] d, input bit c);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        clear_cnt  = c;
        @(posedge clk);
        m_step(v, d, c);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    // Asserted between edges so the async path is exercised independently of clk.
    task automatic do_reset();
        #2;
        rst_n      = 1'b0;
        data_valid = 1'b1;
        data_in    = 6'b111111;
        clear_cnt  = 1'b0;
        m_reset();
        #1;
        lit("rst_async_locked", {31'd0, locked}, 32'd0);
        lit("rst_async_err_count", {16'd0, err_count}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n      = 1'b1;
        data_valid = 1'b0;
    endtask

    logic [15:0] exp_cnt1;
    logic [15:0] exp_cnt3;

    initial begin
        build_table();
        exp_cnt1 = CNT_EN ? 16'd1 : 16'd0;
        exp_cnt3 = CNT_EN ? 16'd3 : 16'd0;

        // Reset held with a live all-ones word on the bus.
        rst_n      = 1'b0;
        data_valid = 1'b1;
        data_in    = 6'b111111;
        clear_cnt  = 1'b0;
        m_reset();
        #1;
        lit("reset_locked", {31'd0, locked}, 32'd0);
        lit("reset_err", {31'd0, err}, 32'd0);
        lit("reset_err_count", {16'd0, err_count}, 32'd0);
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_n      = 1'b1;
        data_valid = 1'b0;

        // Acquisition from the first word after reset.
        send(1, 6'b000001, 0);
        send(1, 6'b000010, 0);
        send(1, 6'b000100, 0);
        send(1, 6'b001000, 0);
        lit("acq_before_lock", {31'd0, locked}, 32'd0);
        send(1, 6'b010000, 0);
        lit("acq_locked", {31'd0, locked}, 32'd1);

        // Single corrupted word while locked; flywheel keeps the sequence.
        send(1, 6'b000000, 0);
        lit("single_err", {31'd0, err}, 32'd1);
        lit("single_cnt", {16'd0, err_count}, {16'd0, exp_cnt1});
        lit("single_locked", {31'd0, locked}, 32'd1);
        send(1, 6'b000011, 0);
        lit("single_recover_err", {31'd0, err}, 32'd0);
        lit("single_recover_locked", {31'd0, locked}, 32'd1);

        // Idle cycle while locked holds everything.
        send(0, 6'b101010, 0);
        lit("gap_locked", {31'd0, locked}, 32'd1);

        // Clear coinciding with a counted mismatch.
        send(1, 6'b111111, 1);
        lit("clear_err", {31'd0, err}, 32'd1);
        lit("clear_cnt_zero", {16'd0, err_count}, 32'd0);
        send(1, 6'b001100, 0);
        lit("clear_next_err", {31'd0, err}, 32'd0);

        // Three consecutive misses drop lock.
        send(1, 6'b111111, 0);
        send(1, 6'b111111, 0);
        lit("loss_still_locked", {31'd0, locked}, 32'd1);
        send(1, 6'b111111, 0);
        lit("loss_err", {31'd0, err}, 32'd1);
        lit("loss_cnt", {16'd0, err_count}, {16'd0, exp_cnt3});
        lit("loss_unlocked", {31'd0, locked}, 32'd0);
        send(1, 6'b000001, 0);
        lit("reseed_no_err", {31'd0, err}, 32'd0);
        send(1, 6'b000010, 0);
        send(1, 6'b000100, 0);
        send(1, 6'b001000, 0);
        send(1, 6'b010000, 0);
        lit("relock", {31'd0, locked}, 32'd1);

        // Reset in the middle of acquisition forces a full restart.
        do_reset();
        send(1, 6'b000001, 0);
        send(1, 6'b000010, 0);
        send(1, 6'b000100, 0);
        do_reset();
        send(1, 6'b001000, 0);
        send(1, 6'b010000, 0);
        send(1, 6'b100001, 0);
        send(1, 6'b000011, 0);
        lit("post_reset_not_yet", {31'd0, locked}, 32'd0);
        send(1, 6'b000110, 0);
        lit("post_reset_locked", {31'd0, locked}, 32'd1);

        // Reseed inside acquisition, then a zero word drops back to idle.
        do_reset();
        send(1, 6'b000101, 0);
        send(1, 6'b111000, 0);
        send(1, 6'b110000, 0);
        send(1, 6'b000000, 0);
        send(1, 6'b100001, 0);
        send(1, 6'b000011, 0);
        send(1, 6'b000110, 0);
        lit("reseed_idle_unlocked", {31'd0, locked}, 32'd0);

        // Zero words in idle never start acquisition.
        do_reset();
        for (int i = 0; i < 10; i++) send(1, 6'b000000, 0);
        lit("zeros_idle", {31'd0, locked}, 32'd0);

        // Gaps interleaved in an acquisition sequence.
        send(1, 6'b000001, 0);
        send(0, 6'b000000, 0);
        send(1, 6'b000010, 0);
        send(0, 6'b111111, 0);
        send(0, 6'b000000, 0);
        send(1, 6'b000100, 0);
        send(1, 6'b001000, 0);
        send(0, 6'b000000, 0);
        lit("gaps_not_yet", {31'd0, locked}, 32'd0);
        send(1, 6'b010000, 0);
        lit("gaps_locked", {31'd0, locked}, 32'd1);

        // A longer locked run along the orbit, with one miss at the wrap.
        for (int i = 5; i < 70; i++) send(1, (i == 62) ? 6'b010101 : seq[i % 63], 0);
        lit("long_run_locked", {31'd0, locked}, 32'd1);
        lit("long_run_cnt", {16'd0, err_count}, {16'd0, exp_cnt1});

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/lfsr_6bit_checker.md
LFSR_6BIT_CHECKER -- requirements
Module: lfsr_6bit_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words required to declare lock (legal 1..15).
REQ-002 SHALL have parameter LOSS_THRESHOLD, default 3: consecutive mismatching words while locked that force resync (legal 1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port data_valid, input, 1: data_in holds one LFSR state word this cycle.
REQ-006 SHALL have port data_in, input, 6: received LFSR state word.
REQ-007 SHALL have port clear_cnt, input, 1: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1: registered; high while in LOCKED.
REQ-009 SHALL have port err, output, 1: registered one-cycle pulse per mismatching word in LOCKED.
REQ-010 SHALL have port err_count, output, 16: saturating count of mismatches in LOCKED.

Function
REQ-011 SHALL compute next(s) = {s[4:0], s[5]^s[4]} (x^6+x^5+1, shift-left, maximal length 63).
REQ-012 SHALL implement states IDLE, SYNC, LOCKED; all transitions and outputs depend on data_valid=1 cycles only; data_valid=0 holds all state.
REQ-013 IDLE: valid non-zero word -> expected <= next(data_in), match_cnt <= 0, go SYNC; valid 6'b000000 -> stay IDLE.
REQ-014 SYNC: data_in == expected -> match_cnt+1, expected <= next(data_in); on LOCK_COUNT-th consecutive match go LOCKED.
REQ-015 SYNC: mismatch with non-zero data_in -> reseed (expected <= next(data_in), match_cnt <= 0), stay SYNC; mismatch with 6'b000000 -> IDLE.
REQ-016 LOCKED: expected <= next(expected) every valid word (flywheel, no reseed); match clears err_run; mismatch increments err_run and pulses err.
REQ-017 LOCKED: when err_run reaches LOSS_THRESHOLD, go IDLE in the same update; locked falls the cycle after that word.
REQ-018 Latency: locked, err, err_count reflect a sampled word on the clock edge that samples it (visible the following cycle).
REQ-019 err_count SHALL saturate at 16'hFFFF; no wrap-around.
REQ-020 clear_cnt and a counted mismatch in the same cycle -> err_count = 0 (clear wins); err still pulses.
REQ-021 err SHALL never assert in IDLE or SYNC.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, expected = 0, match_cnt = 0, err_run = 0, locked = 0, err = 0, err_count = 0, regardless of clk.
REQ-023 Reset deasserted mid-sequence SHALL require full re-acquisition (seed plus LOCK_COUNT matches).

Configuration
REQ-024 Macro LFSR_CHK_ERR_CNT_EN defined: err_count counter implemented per REQ-010/019/020.
REQ-025 Macro LFSR_CHK_ERR_CNT_EN undefined: no counter register; err_count tied to 16'h0000, clear_cnt ignored; err, locked, FSM unchanged.

Verification
REQ-026 rst_n=0 with data_valid=1, data_in=6'b111111 -> locked=0, err=0, err_count=0 throughout; after release, first valid word starts acquisition.
REQ-027 Defaults; valid words 000001,000010,000100,001000,010000 -> locked=1 the cycle after 010000; locked=0 before.
REQ-028 Locked after REQ-027; send 000000 instead of 100001, then 000011 -> err pulses once, err_count=1, locked stays 1, no further err.
REQ-029 Locked; three consecutive wrong words (e.g. 111111 each) -> err pulses three cycles, err_count=3, locked=0 the cycle after the third; then 000001 re-seeds into SYNC.
REQ-030 IDLE; data_in=000000 valid for 10 cycles -> stays IDLE, locked=0; data_valid=0 gaps inside a locking sequence do not break lock acquisition.
REQ-031 Locked, clear_cnt=1 on a mismatch cycle -> err=1, err_count=0; rerun REQ-028 with LFSR_CHK_ERR_CNT_EN undefined -> err_count=0, err still pulses.
